mem_image_writer: RTL

- Serializes a region of simulator memory into the ASCII load-image format that the simulator's file loader consumes.
- Output format is one `*` start-PC record, one `@` base-address record, then one `-` record per 16-bit word.
- Sits beside the memory model and drives a byte-wide valid/ready character stream toward a file or console sink, so dumped images reload unchanged.

---
 rtl/mem_image_writer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_image_writer.sv
// mem_image_writer: dumps a block of 16-bit memory words as an ASCII load
// image (`*` start-PC record, `@` base record, one `-` record per word) on a
// byte-wide valid/ready character stream.
module mem_image_writer #(
  parameter int ADDR_W    = 16,
  parameter int COUNT_W   = 16,
  parameter int EMIT_STAR = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [15:0]        start_pc,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] word_count,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [15:0]        mem_rdata,
  output logic [7:0]         out_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE, S_STAR, S_AT, S_FETCH, S_WAIT, S_DATA, S_FINISH
  } state_t;

  state_t             state_reg;
  logic [2:0]         idx_reg;    // character position within the current record
  logic [15:0]        val_reg;    // value being formatted in the current record
  logic [ADDR_W-1:0]  addr_reg;   // next word address to read
  logic [COUNT_W-1:0] count_reg;  // words still to be dumped

  logic               xfer;
  logic               last;
  logic [ADDR_W-1:0]  base_even;
  logic [ADDR_W-1:0]  addr_next;

  assign xfer      = out_valid && out_ready;
  assign last      = (idx_reg == 3'd7);
  assign base_even = base_addr & ~ADDR_W'(1);
  assign addr_next = addr_reg + ADDR_W'(2);

  // Character n (1..7) of a record: six octal digits MSB first, then newline.
  // The first digit only carries bit 15.
  function automatic logic [7:0] record_char(input logic [15:0] v, input logic [2:0] n);
    logic [2:0] d;
    d = 3'd0;
    case (n)
      3'd1: d = {2'b00, v[15]};
      3'd2: d = v[14:12];
      3'd3: d = v[11:9];
      3'd4: d = v[8:6];
      3'd5: d = v[5:3];
      3'd6: d = v[2:0];
      default: d = 3'd0;
    endcase
    return (n == 3'd7) ? 8'h0A : (8'h30 + {5'b00000, d});
  endfunction

  // Dump sequencer: all outputs are registered and change only on state moves
  // or accepted characters, so out_char holds steady while the sink stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= 3'd0;
      val_reg   <= 16'd0;
      addr_reg  <= '0;
      count_reg <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      out_char  <= 8'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Advance within a record; the newline transfer is handled per state.
      if (xfer && !last) begin
        idx_reg  <= idx_reg + 3'd1;
        out_char <= record_char(val_reg, idx_reg + 3'd1);
      end

      case (state_reg)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr_reg  <= base_even;
            count_reg <= word_count;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            idx_reg   <= 3'd0;
            if (EMIT_STAR != 0) begin
              state_reg <= S_STAR;
              out_char  <= 8'h2A;
              val_reg   <= start_pc;
            end else begin
              state_reg <= S_AT;
              out_char  <= 8'h40;
              val_reg   <= 16'(base_even);
            end
          end
        end

        S_STAR: begin
          if (xfer && last) begin
            state_reg <= S_AT;
            idx_reg   <= 3'd0;
            out_char  <= 8'h40;
            val_reg   <= 16'(addr_reg);
          end
        end

        S_AT: begin
          if (xfer && last) begin
            idx_reg   <= 3'd0;
            out_valid <= 1'b0;
            if (count_reg != '0) begin
              state_reg <= S_FETCH;
              mem_rd    <= 1'b1;
              mem_addr  <= addr_reg;
            end else begin
              state_reg <= S_FINISH;
              done      <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end

        S_FETCH: begin
          mem_rd    <= 1'b0;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          val_reg   <= mem_rdata;
          out_char  <= 8'h2D;
          out_valid <= 1'b1;
          idx_reg   <= 3'd0;
          state_reg <= S_DATA;
        end

        S_DATA: begin
          if (xfer && last) begin
            idx_reg   <= 3'd0;
            out_valid <= 1'b0;
            count_reg <= count_reg - COUNT_W'(1);
            addr_reg  <= addr_next;
            if (count_reg != COUNT_W'(1)) begin
              state_reg <= S_FETCH;
              mem_rd    <= 1'b1;
              mem_addr  <= addr_next;
            end else begin
              state_reg <= S_FINISH;
              done      <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end

        S_FINISH: begin
          done      <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
